// File: rtl/dmc_pkg.sv
// Shared constants for the direct-mapped instruction cache line-fill controller.
// Address split: offset [3:0], index [8:4], tag [23:9].
package dmc_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_W     = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned HALF_W     = 64;
    localparam int unsigned WSEL_W     = 2;

    localparam int unsigned OFF_LSB = 0;
    localparam int unsigned OFF_MSB = 3;
    localparam int unsigned IDX_LSB = 4;
    localparam int unsigned IDX_MSB = 8;
    localparam int unsigned TAG_LSB = 9;
    localparam int unsigned TAG_MSB = 23;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CHECK = 2'd1;
    localparam state_t ST_FILL  = 2'd2;
    localparam state_t ST_WRITE = 2'd3;

endpackage

// File: rtl/dmc_line_buf.sv
// Four-word line assembly buffer; word 0 sits in the least significant bits.
module dmc_line_buf
    import dmc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        sel,
    input  logic [WORD_W-1:0] din,
    output logic [LINE_W-1:0] c_line
);

    logic [WORD_W-1:0] words_q [LINE_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else if (we) begin
            words_q[sel] <= din;
        end
    end

    always_comb begin
        c_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            c_line[i*WORD_W +: WORD_W] = words_q[i];
        end
    end

endmodule

// File: rtl/dmc_line_fill.sv
// Miss handling and line fill for the 32-line x 16-byte direct-mapped I-cache.
// Hits return a half-line in two cycles; misses fetch four words, write the line, then re-check.
module dmc_line_fill
    import dmc_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [HALF_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [ADDR_W-1:0] c_A,
    output logic [ADDR_W-1:0] c_A_h,
    input  logic [HALF_W-1:0] c_Do,
    input  logic              c_hit,
    output logic [LINE_W-1:0] c_line,
    output logic              c_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    input  logic [WORD_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WSEL_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [HALF_W-1:0]   rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic                buf_we;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wcnt_d        = wcnt_q;
        miss_cnt_d    = miss_cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        buf_we        = 1'b0;
        req_ready     = 1'b0;
        m_rd          = 1'b0;
        c_wr          = 1'b0;
        c_A           = addr_q;
        c_A_h         = addr_q;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                c_A       = req_addr;
                c_A_h     = req_addr;
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (c_hit) begin
                    rdata_d       = c_Do;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    wcnt_d  = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                m_rd = 1'b1;
                if (m_ack) begin
                    buf_we = 1'b1;
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == WSEL_W'(LINE_WORDS - 1)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Re-check after the write so the hit path returns the data.
                c_wr    = 1'b1;
                state_d = ST_CHECK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wcnt_q        <= '0;
            miss_cnt_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wcnt_q        <= wcnt_d;
            miss_cnt_q    <= miss_cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Word address only advances after an ack, so it is stable across wait states.
    assign m_addr      = {addr_q[ADDR_W-1:IDX_LSB], wcnt_q, 2'b00};
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign miss_cnt    = miss_cnt_q;

    dmc_line_buf u_line_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (buf_we),
        .sel    (wcnt_q),
        .din    (m_rdata),
        .c_line (c_line)
    );

endmodule

// File: tb/tb_dmc_line_fill.sv
// Directed bench for dmc_line_fill with a behavioural cache array and wait-state memory.
module tb_dmc_line_fill;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [23:0]   req_addr;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   rdata;
    logic          rdata_valid;
    logic [23:0]   c_A;
    logic [23:0]   c_A_h;
    logic [63:0]   c_Do;
    logic          c_hit;
    logic [127:0]  c_line;
    logic          c_wr;
    logic [23:0]   m_addr;
    logic          m_rd;
    logic [31:0]   m_rdata;
    logic          m_ack;
    logic [15:0]   miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmc_line_fill dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_addr    (req_addr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .c_A         (c_A),
        .c_A_h       (c_A_h),
        .c_Do        (c_Do),
        .c_hit       (c_hit),
        .c_line      (c_line),
        .c_wr        (c_wr),
        .m_addr      (m_addr),
        .m_rd        (m_rd),
        .m_rdata     (m_rdata),
        .m_ack       (m_ack),
        .miss_cnt    (miss_cnt)
    );

    // Cache array model: 32 lines, tag [23:9], index [8:4], half select [3].
    logic [31:0]  cvalid = '0;
    logic [14:0]  ctag [32];
    logic [127:0] cdat [32];

    assign c_hit = cvalid[c_A_h[8:4]] && (ctag[c_A_h[8:4]] == c_A_h[23:9]);
    assign c_Do  = c_A[3] ? cdat[c_A[8:4]][127:64] : cdat[c_A[8:4]][63:0];

    always @(posedge clk) begin
        if (c_wr) begin
            cvalid[c_A[8:4]] <= 1'b1;
            ctag[c_A[8:4]]   <= c_A[23:9];
            cdat[c_A[8:4]]   <= c_line;
        end
    end

    // Memory model: wait_cfg idle cycles before each ack.
    int wait_cfg = 0;
    int wcyc     = 0;

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        if (a[23:4] == 20'h00012) begin
            return 32'h11111111 * (32'(a[3:2]) + 32'd1);
        end
        return {8'hD0, a};
    endfunction

    assign m_ack   = m_rd && (wcyc == wait_cfg);
    assign m_rdata = mem_word(m_addr);

    always @(posedge clk) begin
        if (!m_rd || m_ack) wcyc <= 0;
        else                wcyc <= wcyc + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Observations from the most recent request.
    int           lat;
    int           n_ack;
    int           n_wr;
    int           n_rd;
    int           unstable;
    int           ack_at_wr;
    logic [23:0]  ack_addr [16];
    logic [127:0] wr_line;
    logic [63:0]  got;
    logic         ready_at_done;

    task automatic run_req(input logic [23:0] a, input int w);
        logic        prev_rd;
        logic        prev_ack;
        logic [23:0] prev_addr;
        wait_cfg = w;
        @(negedge clk);
        req_addr  = a;
        req_valid = 1'b1;
        lat = 0; n_ack = 0; n_wr = 0; n_rd = 0; unstable = 0; ack_at_wr = -1;
        wr_line = '0; got = '0; ready_at_done = 1'b0;
        prev_rd = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        for (int i = 0; i < 16; i++) ack_addr[i] = '0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (m_rd) n_rd++;
            if (m_rd && prev_rd && !prev_ack && m_addr != prev_addr) unstable++;
            if (m_rd && m_ack) begin
                if (n_ack < 16) ack_addr[n_ack] = m_addr;
                n_ack++;
            end
            if (c_wr) begin
                n_wr++;
                wr_line = c_line;
                if (n_wr == 1) ack_at_wr = n_ack;
            end
            if (rdata_valid) begin
                lat = k;
                got = rdata;
                ready_at_done = req_ready;
            end
            prev_rd   = m_rd;
            prev_ack  = m_ack;
            prev_addr = m_addr;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k1, k2;
        logic [63:0] d1, d2;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready",   128'(req_ready),   128'd1);
        check("rst_rdata",       128'(rdata),       128'd0);
        check("rst_rdata_valid", 128'(rdata_valid), 128'd0);
        check("rst_c_wr",        128'(c_wr),        128'd0);
        check("rst_c_line",      c_line,            128'd0);
        check("rst_m_rd",        128'(m_rd),        128'd0);
        check("rst_m_addr",      128'(m_addr),      128'd0);
        check("rst_miss_cnt",    128'(miss_cnt),    128'd0);
        rst_n = 1'b1;

        // Cold miss, zero-wait memory.
        run_req(24'h000120, 0);
        check("cold_latency",  128'(lat),         128'd8);
        check("cold_addr0",    128'(ack_addr[0]), 128'h000120);
        check("cold_addr1",    128'(ack_addr[1]), 128'h000124);
        check("cold_addr2",    128'(ack_addr[2]), 128'h000128);
        check("cold_addr3",    128'(ack_addr[3]), 128'h00012C);
        check("cold_n_ack",    128'(n_ack),       128'd4);
        check("cold_n_wr",     128'(n_wr),        128'd1);
        check("cold_line",     wr_line, 128'h44444444_33333333_22222222_11111111);
        check("cold_rdata",    128'(got),         128'h22222222_11111111);
        check("cold_miss_cnt", 128'(miss_cnt),    128'd1);

        // Hit on the upper half of the same line.
        run_req(24'h000128, 0);
        check("hit_latency",  128'(lat),           128'd2);
        check("hit_rdata",    128'(got),           128'h44444444_33333333);
        check("hit_no_m_rd",  128'(n_rd),          128'd0);
        check("hit_no_c_wr",  128'(n_wr),          128'd0);
        check("hit_ready",    128'(ready_at_done), 128'd1);
        check("hit_miss_cnt", 128'(miss_cnt),      128'd1);

        // Three wait states before each ack.
        run_req(24'h000548, 3);
        check("wait_latency",  128'(lat),         128'd20);
        check("wait_stable",   128'(unstable),    128'd0);
        check("wait_n_ack",    128'(n_ack),       128'd4);
        check("wait_addr3",    128'(ack_addr[3]), 128'h00054C);
        check("wait_n_wr",     128'(n_wr),        128'd1);
        check("wait_rdata",    128'(got),         128'hD000054C_D0000548);
        check("wait_miss_cnt", 128'(miss_cnt),    128'd2);

        // Conflict: same index 0x12, different tag.
        run_req(24'h000320, 0);
        check("conf_latency",  128'(lat),         128'd8);
        check("conf_addr0",    128'(ack_addr[0]), 128'h000320);
        check("conf_rdata",    128'(got),         128'hD0000324_D0000320);
        check("conf_miss_cnt", 128'(miss_cnt),    128'd3);

        // Re-request of the evicted line misses; reset after two acks.
        wait_cfg = 0;
        @(negedge clk);
        req_addr  = 24'h000120;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("refetch_m_rd",  128'(m_rd),   128'd1);
        check("refetch_addr0", 128'(m_addr), 128'h000120);
        @(negedge clk);
        check("refetch_addr1", 128'(m_addr), 128'h000124);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_m_rd",        128'(m_rd),        128'd0);
        check("mrst_m_addr",      128'(m_addr),      128'd0);
        check("mrst_c_line",      c_line,            128'd0);
        check("mrst_c_wr",        128'(c_wr),        128'd0);
        check("mrst_req_ready",   128'(req_ready),   128'd1);
        check("mrst_rdata",       128'(rdata),       128'd0);
        check("mrst_rdata_valid", 128'(rdata_valid), 128'd0);
        check("mrst_miss_cnt",    128'(miss_cnt),    128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(24'h000120, 0);
        check("refill_addr0",    128'(ack_addr[0]), 128'h000120);
        check("refill_wr_after", 128'(ack_at_wr),   128'd4);
        check("refill_n_wr",     128'(n_wr),        128'd1);
        check("refill_latency",  128'(lat),         128'd8);
        check("refill_rdata",    128'(got),         128'h22222222_11111111);
        check("refill_miss_cnt", 128'(miss_cnt),    128'd1);

        // Backpressure: a second request held during the fill waits for req_ready.
        wait_cfg = 0;
        @(negedge clk);
        req_addr  = 24'h000320;
        req_valid = 1'b1;
        k1 = 0; k2 = 0; d1 = '0; d2 = '0;
        for (int k = 1; k <= 40 && k2 == 0; k++) begin
            @(negedge clk);
            if (k == 1) req_addr = 24'h000548;
            if (k == 9) req_valid = 1'b0;
            if (k == 3) check("bp_not_ready", 128'(req_ready), 128'd0);
            if (rdata_valid) begin
                if (k1 == 0) begin
                    k1 = k;
                    d1 = rdata;
                end else begin
                    k2 = k;
                    d2 = rdata;
                end
            end
        end
        req_valid = 1'b0;
        check("bp_first_lat",  128'(k1),       128'd8);
        check("bp_first_data", 128'(d1),       128'hD0000324_D0000320);
        check("bp_second_lat", 128'(k2),       128'd10);
        check("bp_second_dat", 128'(d2),       128'hD000054C_D0000548);
        check("bp_miss_cnt",   128'(miss_cnt), 128'd2);

        // Saturation: preload the counter just below all-ones.
        @(negedge clk);
        force dut.miss_cnt_q = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        run_req(24'h000120, 0);
        check("sat_rdata",  128'(got),      128'h22222222_11111111);
        check("sat_first",  128'(miss_cnt), 128'hFFFF);
        run_req(24'h000320, 0);
        check("sat_held",   128'(miss_cnt), 128'hFFFF);
        check("sat_rdata2", 128'(got),      128'hD0000324_D0000320);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
